// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, runs the bus read handshake and
// feeds IF/ID with instructions, NOP bubbles, stall hold and redirects.
module if_fetch #(
  parameter logic [29:0] RESET_VECTOR = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  input  logic        bus_rdy_,
  input  logic [31:0] bus_rd_data,
  output logic [29:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [29:0] fetch_pc_q, fetch_pc_d;
  logic [29:0] if_pc_q, if_pc_d;
  logic [31:0] if_insn_q, if_insn_d;
  logic        if_en_q, if_en_d;
  logic        bus_req_n_q, bus_req_n_d;
  logic        bus_as_n_q, bus_as_n_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic        hold_valid_q, hold_valid_d;
  logic [29:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_insn_q, hold_insn_d;
  logic        discard_q, discard_d;

  logic        redir;
  logic [29:0] redir_pc;
  logic        inflight;
  logic        rdy;
  logic [29:0] pc_inc;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    if_pc_d      = if_pc_q;
    if_insn_d    = if_insn_q;
    if_en_d      = if_en_q;
    bus_req_n_d  = bus_req_n_q;
    bus_as_n_d   = bus_as_n_q;
    bus_addr_d   = bus_addr_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_insn_d  = hold_insn_q;
    discard_d    = discard_q;

    redir    = flush | (br_taken & ~stall);
    redir_pc = flush ? new_pc : br_addr;
    // an access is outstanding whenever the strobe is driven in ACCESS
    inflight = (state_q == ACCESS) & ~bus_as_n_q;
    rdy      = inflight & ~bus_rdy_;
    pc_inc   = fetch_pc_q + 30'd1;

    case (state_q)
      IDLE: begin
        state_d     = REQ;
        bus_req_n_d = 1'b0;
      end
      REQ: begin
        if (!bus_grnt_) begin
          state_d    = ACCESS;
          bus_as_n_d = 1'b0;
          bus_addr_d = redir ? redir_pc : fetch_pc_q;
        end
      end
      ACCESS: begin
        if (!stall) begin
          if_en_d   = 1'b0;
          if_insn_d = 32'h0;
        end
        if (redir) begin
          // a pending read is allowed to finish; its data is dropped later
          if (inflight && bus_rdy_) begin
            discard_d = 1'b1;
          end else begin
            discard_d  = 1'b0;
            bus_as_n_d = 1'b0;
            bus_addr_d = redir_pc;
          end
        end else if (rdy) begin
          if (discard_q) begin
            discard_d  = 1'b0;
            bus_addr_d = fetch_pc_q;
          end else if (stall) begin
            hold_valid_d = 1'b1;
            hold_pc_d    = bus_addr_q;
            hold_insn_d  = bus_rd_data;
            fetch_pc_d   = pc_inc;
            bus_as_n_d   = 1'b1;
          end else begin
            if_pc_d    = bus_addr_q;
            if_insn_d  = bus_rd_data;
            if_en_d    = 1'b1;
            fetch_pc_d = pc_inc;
            bus_addr_d = pc_inc;
          end
        end else if (!inflight && hold_valid_q && !stall) begin
          if_pc_d      = hold_pc_q;
          if_insn_d    = hold_insn_q;
          if_en_d      = 1'b1;
          hold_valid_d = 1'b0;
          bus_as_n_d   = 1'b0;
          bus_addr_d   = fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redir) begin
      fetch_pc_d   = redir_pc;
      if_en_d      = 1'b0;
      if_insn_d    = 32'h0;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_VECTOR;
      if_pc_q      <= RESET_VECTOR;
      if_insn_q    <= 32'h0;
      if_en_q      <= 1'b0;
      bus_req_n_q  <= 1'b1;
      bus_as_n_q   <= 1'b1;
      bus_addr_q   <= 30'h0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= 30'h0;
      hold_insn_q  <= 32'h0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      if_pc_q      <= if_pc_d;
      if_insn_q    <= if_insn_d;
      if_en_q      <= if_en_d;
      bus_req_n_q  <= bus_req_n_d;
      bus_as_n_q   <= bus_as_n_d;
      bus_addr_q   <= bus_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_insn_q  <= hold_insn_d;
      discard_q    <= discard_d;
    end
  end

  assign bus_req_ = bus_req_n_q;
  assign bus_as_  = bus_as_n_q;
  assign bus_rw   = 1'b1;
  assign bus_addr = bus_addr_q;
  assign if_pc    = if_pc_q;
  assign if_insn  = if_insn_q;
  assign if_en    = if_en_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed plan walk plus randomized bus/stall/redirect
// traffic, all checked against an in-order instruction stream model.
module tb_if_fetch;
  localparam logic [29:0] RV = 30'h100;

  logic        clk, reset, stall, flush, br_taken;
  logic [29:0] new_pc, br_addr;
  logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] bus_addr;
  logic [31:0] bus_rd_data;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;

  int n_chk = 0;
  int n_bad = 0;
  int n_valid = 0;

  if_fetch #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_rdy_(bus_rdy_), .bus_rd_data(bus_rd_data),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en)
  );

  function automatic logic [31:0] mem(input logic [29:0] a);
    return {2'b10, a} ^ 32'h0F0F_0F0F;
  endfunction

  // memory slave: returns the word at the address currently on the bus
  assign bus_rd_data = mem(bus_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stream model: valid outputs must follow exp_pc, restarting at each redirect
  logic        m_r, m_s, m_f, m_b;
  logic [29:0] m_np, m_ba, exp_pc, m_pc;
  logic [31:0] m_insn;
  logic        m_en;

  always begin
    @(posedge clk);
    m_r = reset; m_s = stall; m_f = flush; m_b = br_taken;
    m_np = new_pc; m_ba = br_addr;
    #1;
    if (!m_r || !reset) begin
      exp_pc = RV; m_en = 1'b0; m_insn = 32'h0; m_pc = RV;
    end else if (m_f || (m_b && !m_s)) begin
      chk("redir_en", {31'h0, if_en}, 32'h0);
      chk("redir_insn", if_insn, 32'h0);
      exp_pc = m_f ? m_np : m_ba;
      m_en = 1'b0; m_insn = 32'h0;
    end else if (m_s) begin
      chk("stall_en", {31'h0, if_en}, {31'h0, m_en});
      chk("stall_insn", if_insn, m_insn);
      if (m_en) chk("stall_pc", {2'b0, if_pc}, {2'b0, m_pc});
    end else if (if_en) begin
      chk("seq_pc", {2'b0, if_pc}, {2'b0, exp_pc});
      chk("seq_insn", if_insn, mem(exp_pc));
      m_en = 1'b1; m_pc = exp_pc; m_insn = mem(exp_pc);
      exp_pc = exp_pc + 30'd1;
      n_valid++;
    end else begin
      chk("bubble_insn", if_insn, 32'h0);
      m_en = 1'b0; m_insn = 32'h0;
    end
  end

  task automatic chk_out(input string tag, input logic en, input logic [29:0] pc);
    chk({tag, "_en"}, {31'h0, if_en}, {31'h0, en});
    if (en) begin
      chk({tag, "_pc"}, {2'b0, if_pc}, {2'b0, pc});
      chk({tag, "_insn"}, if_insn, mem(pc));
    end else begin
      chk({tag, "_insn"}, if_insn, 32'h0);
    end
  endtask

  task automatic chk_bus(input string tag, input logic as_n, input logic [29:0] addr);
    chk({tag, "_as"}, {31'h0, bus_as_}, {31'h0, as_n});
    if (!as_n) chk({tag, "_addr"}, {2'b0, bus_addr}, {2'b0, addr});
  endtask

  task automatic restart();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
  endtask

  int nv0;

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0; bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
    tick(); tick();
    chk("rst_req", {31'h0, bus_req_}, 32'h1);
    chk("rst_as", {31'h0, bus_as_}, 32'h1);
    chk("rst_addr", {2'b0, bus_addr}, 32'h0);
    chk("rst_rw", {31'h0, bus_rw}, 32'h1);
    chk("rst_pc", {2'b0, if_pc}, {2'b0, RV});
    chk_out("rst", 1'b0, RV);

    // sequential fetch on a zero-wait bus
    reset = 1'b1;
    tick();
    chk("t1_req", {31'h0, bus_req_}, 32'h0);
    chk("t1_as_idle", {31'h0, bus_as_}, 32'h1);
    tick(); chk_bus("t1_grant", 1'b0, 30'h100);
    tick(); chk_out("t1_a", 1'b1, 30'h100);
    tick(); chk_out("t1_b", 1'b1, 30'h101);
    tick(); chk_out("t1_c", 1'b1, 30'h102);

    // wait states on the fetch of 0x101
    restart();
    chk_out("t2_first", 1'b1, 30'h100);
    chk_bus("t2_bus", 1'b0, 30'h101);
    bus_rdy_ = 1'b1;
    tick(); chk_out("t2_w1", 1'b0, 30'h0); chk_bus("t2_w1b", 1'b0, 30'h101);
    tick(); chk_out("t2_w2", 1'b0, 30'h0);
    bus_rdy_ = 1'b0;
    tick(); chk_out("t2_ok", 1'b1, 30'h101);

    // stall while the word for 0x102 returns
    stall = 1'b1;
    tick(); chk_out("t3_h1", 1'b1, 30'h101); chk_bus("t3_h1b", 1'b1, 30'h0);
    tick(); chk_out("t3_h2", 1'b1, 30'h101); chk_bus("t3_h2b", 1'b1, 30'h0);
    tick(); chk_out("t3_h3", 1'b1, 30'h101); chk_bus("t3_h3b", 1'b1, 30'h0);
    stall = 1'b0;
    tick(); chk_out("t3_drain", 1'b1, 30'h102); chk_bus("t3_reiss", 1'b0, 30'h103);

    // branch while the fetch of 0x103 is pending
    bus_rdy_ = 1'b1; br_taken = 1'b1; br_addr = 30'h200;
    tick(); chk_out("t4_br", 1'b0, 30'h0); chk_bus("t4_keep", 1'b0, 30'h103);
    br_taken = 1'b0; bus_rdy_ = 1'b0;
    tick(); chk_out("t4_drop", 1'b0, 30'h0); chk_bus("t4_tgt", 1'b0, 30'h200);
    tick(); chk_out("t4_valid", 1'b1, 30'h200);

    // flush beats branch, and clears a filled hold buffer
    stall = 1'b1;
    tick(); chk_bus("t5_hold", 1'b1, 30'h0);
    flush = 1'b1; new_pc = 30'h40; br_taken = 1'b1; br_addr = 30'h200;
    tick(); chk_out("t5_fl", 1'b0, 30'h0); chk_bus("t5_tgt", 1'b0, 30'h40);
    flush = 1'b0; br_taken = 1'b0; stall = 1'b0;
    tick(); chk_out("t5_valid", 1'b1, 30'h40);

    // wrap of the fetch PC, then asynchronous reset mid-access
    flush = 1'b1; new_pc = 30'h3FFF_FFFF;
    tick(); chk_out("t6_fl", 1'b0, 30'h0); chk_bus("t6_tgt", 1'b0, 30'h3FFF_FFFF);
    flush = 1'b0;
    tick(); chk_out("t6_top", 1'b1, 30'h3FFF_FFFF);
    tick(); chk_out("t6_wrap", 1'b1, 30'h0);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_as", {31'h0, bus_as_}, 32'h1);
    chk("t6_async_req", {31'h0, bus_req_}, 32'h1);
    chk("t6_async_en", {31'h0, if_en}, 32'h0);

    // randomized traffic
    tick();
    reset = 1'b1;
    nv0 = n_valid;
    for (int i = 0; i < 3000; i++) begin
      bus_grnt_ = ($urandom_range(0, 3) == 0);
      bus_rdy_  = ($urandom_range(0, 9) < 3);
      stall     = ($urandom_range(0, 9) < 2);
      flush     = ($urandom_range(0, 39) == 0);
      br_taken  = ($urandom_range(0, 19) == 0);
      new_pc    = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      br_addr   = 30'($urandom);
      tick();
    end
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0; bus_rdy_ = 1'b0;
    tick(); tick();
    chk("rand_progress", {31'h0, (n_valid - nv0) > 300}, 32'h1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
